// File: rtl/mem_access_stage.sv
// MIPS MEM stage: byte-addressable big-endian data RAM with fixed wait states,
// upstream stall generation and a built-in MEM/WB output register.
module mem_access_stage #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_signed_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] PB_in,
    input  logic [4:0]  destination_in,
    output logic        stall,
    output logic [31:0] wb_data_out,
    output logic [4:0]  destination_out,
    output logic        reg_write_out,
    output logic        align_fault_out
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    logic [7:0] ram [DEPTH];

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_op;
    logic             access;
    logic             misaligned;
    logic             fault;
    logic             wb_from_load;
    logic [31:0]      load_value;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    logic [DEPTH_LOG2-1:0] a0, a1, a2, a3;

    assign mem_op       = mem_read_in | mem_write_in;
    assign wb_from_load = mem_read_in & ~mem_write_in & mem_to_reg_in;

    // Addresses wrap modulo DEPTH; upper address bits are ignored.
    assign a0 = alu_result_in[DEPTH_LOG2-1:0];
    assign a1 = a0 + DEPTH_LOG2'(1);
    assign a2 = a0 + DEPTH_LOG2'(2);
    assign a3 = a0 + DEPTH_LOG2'(3);

    always_comb begin
        unique case (mem_size_in)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = alu_result_in[0];
            default: misaligned = (alu_result_in[1:0] != 2'b00);
        endcase
    end

    assign fault = mem_op & misaligned;

    // Wait-state sequencer: access fires on the edge where stall is low.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        stall  = 1'b0;
        access = 1'b0;
        if (busy_q) begin
            if (cnt_q != '0) begin
                stall = 1'b1;
                cnt_d = cnt_q - 1'b1;
            end else begin
                access = 1'b1;
                busy_d = 1'b0;
            end
        end else if (mem_op) begin
            if (WAIT_STATES == 0) begin
                access = 1'b1;
            end else begin
                stall  = 1'b1;
                busy_d = 1'b1;
                cnt_d  = CNT_INIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign byte_v = ram[a0];
    assign half_v = {ram[a0], ram[a1]};
    assign word_v = {ram[a0], ram[a1], ram[a2], ram[a3]};

    always_comb begin
        unique case (mem_size_in)
            2'b00:   load_value = mem_signed_in ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            2'b01:   load_value = mem_signed_in ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            default: load_value = word_v;
        endcase
        if (fault) begin
            load_value = '0;
        end
    end

    // RAM contents survive reset; a store is only committed on its access edge.
    always_ff @(posedge clk) begin
        if (!reset && access && mem_write_in && !fault) begin
            unique case (mem_size_in)
                2'b00: ram[a0] <= PB_in[7:0];
                2'b01: begin
                    ram[a0] <= PB_in[15:8];
                    ram[a1] <= PB_in[7:0];
                end
                default: begin
                    ram[a0] <= PB_in[31:24];
                    ram[a1] <= PB_in[23:16];
                    ram[a2] <= PB_in[15:8];
                    ram[a3] <= PB_in[7:0];
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stall) begin
            wb_data_out     <= '0;
            destination_out <= '0;
            reg_write_out   <= 1'b0;
            align_fault_out <= 1'b0;
        end else begin
            wb_data_out     <= wb_from_load ? load_value : alu_result_in;
            destination_out <= destination_in;
            reg_write_out   <= reg_write_in & ~fault;
            align_fault_out <= fault;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: one 2-wait-state and one zero-wait-state instance
// share stimulus; a vector table plus a reset-abort sequence drive both.
module tb_mem_access_stage;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sgn;
        logic        rw;
        logic        m2r;
        logic [31:0] alu;
        logic [31:0] pb;
        logic [4:0]  dst;
        logic [31:0] exp_wb;
        logic [4:0]  exp_dst;
        logic        exp_rw;
        logic        exp_fault;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset2, reset0;
    logic        mem_read_in, mem_write_in, mem_signed_in, reg_write_in, mem_to_reg_in;
    logic [1:0]  mem_size_in;
    logic [31:0] alu_result_in, PB_in;
    logic [4:0]  destination_in;

    logic        stall2, rw2, fault2, stall0, rw0, fault0;
    logic [31:0] wb2, wb0;
    logic [4:0]  dst2, dst0;

    logic        sel;  // 0 selects the 2-wait-state instance, 1 the zero-wait one
    logic        stall_m, rw_m, fault_m;
    logic [31:0] wb_m;
    logic [4:0]  dst_m;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[17];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    mem_access_stage #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset2),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_size_in(mem_size_in), .mem_signed_in(mem_signed_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .alu_result_in(alu_result_in), .PB_in(PB_in), .destination_in(destination_in),
        .stall(stall2), .wb_data_out(wb2), .destination_out(dst2),
        .reg_write_out(rw2), .align_fault_out(fault2)
    );

    mem_access_stage #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset0),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_size_in(mem_size_in), .mem_signed_in(mem_signed_in),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .alu_result_in(alu_result_in), .PB_in(PB_in), .destination_in(destination_in),
        .stall(stall0), .wb_data_out(wb0), .destination_out(dst0),
        .reg_write_out(rw0), .align_fault_out(fault0)
    );

    always_comb begin
        stall_m = sel ? stall0 : stall2;
        wb_m    = sel ? wb0    : wb2;
        dst_m   = sel ? dst0   : dst2;
        rw_m    = sel ? rw0    : rw2;
        fault_m = sel ? fault0 : fault2;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        mem_read_in = 0; mem_write_in = 0; mem_size_in = 2'b10; mem_signed_in = 0;
        reg_write_in = 0; mem_to_reg_in = 0; alu_result_in = '0; PB_in = '0;
        destination_in = '0;
    endtask

    task automatic drive(input vec_t v);
        mem_read_in = v.rd; mem_write_in = v.wr; mem_size_in = v.size;
        mem_signed_in = v.sgn; reg_write_in = v.rw; mem_to_reg_in = v.m2r;
        alu_result_in = v.alu; PB_in = v.pb; destination_in = v.dst;
    endtask

    // Called at a negedge; returns at the negedge after the op's results appear.
    task automatic run_op(input vec_t v, input int exp_stalls);
        int   n;
        vec_t e;
        drive(v);
        #1;
        n = 0;
        while (stall_m && n < 20) begin
            @(negedge clk);
            #1;
            n++;
            check("bubble", {wb_m[31:8], wb_m[7:0] | {dst_m, rw_m, fault_m, 1'b0}}, 32'h0);
        end
        check("stall_cycles", n, exp_stalls);
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        check("wb_data", wb_m, e.exp_wb);
        check("destination", {27'b0, dst_m}, {27'b0, e.exp_dst});
        check("reg_write", {31'b0, rw_m}, {31'b0, e.exp_rw});
        check("align_fault", {31'b0, fault_m}, {31'b0, e.exp_fault});
    endtask

    initial begin
        vec_t v;
        //          rd wr size  sg rw m2r alu            pb             dst  exp_wb         dst rw f
        vecs[0]  = '{0, 1, 2'b10, 0, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, 32'h0000_0010, 5'd0, 0, 0};
        vecs[1]  = '{1, 0, 2'b10, 0, 1, 1, 32'h0000_0010, 32'h0,         5'd2, 32'hDEAD_BEEF, 5'd2, 1, 0};
        vecs[2]  = '{1, 0, 2'b00, 1, 1, 1, 32'h0000_0010, 32'h0,         5'd3, 32'hFFFF_FFDE, 5'd3, 1, 0};
        vecs[3]  = '{1, 0, 2'b00, 0, 1, 1, 32'h0000_0013, 32'h0,         5'd4, 32'h0000_00EF, 5'd4, 1, 0};
        vecs[4]  = '{1, 0, 2'b01, 1, 1, 1, 32'h0000_0012, 32'h0,         5'd6, 32'hFFFF_BEEF, 5'd6, 1, 0};
        vecs[5]  = '{1, 0, 2'b01, 0, 1, 1, 32'h0000_0010, 32'h0,         5'd8, 32'h0000_DEAD, 5'd8, 1, 0};
        vecs[6]  = '{0, 0, 2'b10, 0, 1, 0, 32'h0000_0042, 32'h0,         5'd5, 32'h0000_0042, 5'd5, 1, 0};
        vecs[7]  = '{1, 0, 2'b10, 0, 1, 1, 32'h0000_0011, 32'h0,         5'd7, 32'h0000_0000, 5'd7, 0, 1};
        vecs[8]  = '{0, 1, 2'b10, 0, 0, 0, 32'h0000_0000, 32'h1122_3344, 5'd0, 32'h0000_0000, 5'd0, 0, 0};
        vecs[9]  = '{0, 1, 2'b01, 0, 0, 0, 32'h0000_0003, 32'h0000_5566, 5'd0, 32'h0000_0003, 5'd0, 0, 1};
        vecs[10] = '{1, 0, 2'b10, 0, 1, 1, 32'h0000_0000, 32'h0,         5'd9, 32'h1122_3344, 5'd9, 1, 0};
        vecs[11] = '{0, 1, 2'b00, 0, 0, 0, 32'h0000_0400, 32'h0000_00AA, 5'd0, 32'h0000_0400, 5'd0, 0, 0};
        vecs[12] = '{1, 0, 2'b00, 0, 1, 1, 32'h0000_0000, 32'h0,         5'd10, 32'h0000_00AA, 5'd10, 1, 0};
        vecs[13] = '{1, 0, 2'b11, 1, 1, 1, 32'h0000_0000, 32'h0,         5'd11, 32'hAA22_3344, 5'd11, 1, 0};
        vecs[14] = '{1, 1, 2'b10, 0, 1, 1, 32'h0000_0020, 32'h5566_7788, 5'd3, 32'h0000_0020, 5'd3, 1, 0};
        vecs[15] = '{1, 0, 2'b10, 0, 1, 1, 32'h0000_0020, 32'h0,         5'd12, 32'h5566_7788, 5'd12, 1, 0};
        vecs[16] = '{1, 0, 2'b00, 1, 1, 1, 32'h0000_0013, 32'h0,         5'd13, 32'hFFFF_FFEF, 5'd13, 1, 0};

        sel = 1'b0;
        drive_idle();
        reset2 = 1'b1;
        reset0 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_wb", wb2, 32'h0);
        check("reset_ctl", {26'b0, dst2, rw2, fault2, stall2}, 32'h0);
        check("reset0_all", {wb0[31:8], wb0[7:0] | {dst0, rw0, fault0, stall0}}, 32'h0);
        reset2 = 1'b0;
        reset0 = 1'b0;

        for (int i = 0; i < 17; i++) run_op(vecs[i], (vecs[i].rd | vecs[i].wr) ? 2 : 0);

        // Reset during the second stall cycle of a store aborts it.
        v = '{0, 1, 2'b10, 0, 0, 0, 32'h30, 32'hCAFE_F00D, 5'd0, 32'h30, 5'd0, 0, 0};
        run_op(v, 2);
        v.pb = 32'h0102_0304;
        drive(v);
        #1;
        check("abort_stall1", {31'b0, stall2}, 32'h1);
        @(negedge clk);
        #1;
        check("abort_stall2", {31'b0, stall2}, 32'h1);
        reset2 = 1'b1;
        @(negedge clk);
        check("abort_outputs", {wb2[31:8], wb2[7:0] | {dst2, rw2, fault2, 1'b0}}, 32'h0);
        reset2 = 1'b0;
        drive_idle();
        #1;
        check("abort_stall_low", {31'b0, stall2}, 32'h0);
        @(negedge clk);
        v = '{1, 0, 2'b10, 0, 1, 1, 32'h30, 32'h0, 5'd14, 32'hCAFE_F00D, 5'd14, 1, 0};
        run_op(v, 2);

        // Zero-wait-state instance: same table, stall must never rise.
        sel = 1'b1;
        for (int i = 0; i < 17; i++) run_op(vecs[i], 0);

        drive_idle();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MIPS MEM stage. Consumes the EX/MEM pipeline register outputs: decoded control, ALU result (address or data), store data PB, and destination.
- Performs byte/halfword/word loads and stores against an internal byte-addressable data RAM that has a fixed number of wait states.
- Stalls the upstream pipeline while an access is in flight.
- Registers the writeback result for the WB stage, so the MEM/WB register is built in.

Parameters:
- DEPTH_LOG2, 10, log2 of data RAM size in bytes (default 1024 B).
- WAIT_STATES, 2, extra cycles per load/store; 0 means a single-cycle access.

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- mem_read_in  input  1  load operation.
- mem_write_in  input  1  store operation.
- mem_size_in  input  2  access size: 00 byte, 01 halfword, 10 word, 11 treated as word.
- mem_signed_in  input  1  sign-extend byte/halfword loads when 1, zero-extend when 0.
- reg_write_in  input  1  instruction writes the register file.
- mem_to_reg_in  input  1  select load data for writeback.
- alu_result_in  input  32  effective address, or ALU data for non-memory ops.
- PB_in  input  32  store data.
- destination_in  input  5  destination register.
- stall  output  1  combinational; hold EX/MEM and all earlier stages.
- wb_data_out  output  32  registered writeback data.
- destination_out  output  5  registered destination.
- reg_write_out  output  1  registered register-file write enable.
- align_fault_out  output  1  registered misaligned-access flag, one cycle.

Behaviour:
- Reset:
  - busy=0, cnt=0, wb_data_out=0, destination_out=0, reg_write_out=0, align_fault_out=0.
  - RAM contents are not cleared; a store presented during reset is ignored.
- Memory op (mem_op) means mem_read_in | mem_write_in. If both are set, the op is treated as a store only: no load, wb_data = alu_result_in.
- Address: RAM index = alu_result_in[DEPTH_LOG2-1:0]. Upper bits are ignored, so addresses alias modulo DEPTH.
- Byte order is big-endian: word = {m[a], m[a+1], m[a+2], m[a+3]}; halfword = {m[a], m[a+1]}.
- Store widths: byte stores PB_in[7:0]; halfword stores PB_in[15:0]; word stores PB_in[31:0].
- Loads:
  - Byte/halfword loads are extended according to mem_signed_in.
  - Word loads ignore mem_signed_in.
- Alignment:
  - A halfword with a[0]=1 is misaligned; a word with a[1:0]!=0 is misaligned.
  - A misaligned op writes nothing, yields load value 0, forces reg_write_out=0 and sets align_fault_out=1 for one cycle.
  - A misaligned op still consumes its wait states.
- Wait-state sequencing:
  - Idle cycle (busy=0) with mem_op:
    - If WAIT_STATES=0: access is performed at this edge; stall=0.
    - Otherwise: stall=1, busy<=1, cnt<=WAIT_STATES-1.
  - busy=1 and cnt!=0: stall=1, cnt<=cnt-1.
  - busy=1 and cnt==0: stall=0, access performed at this edge, busy<=0.
  - Result: stall is high for exactly WAIT_STATES cycles; the op occupies WAIT_STATES+1 cycles; results are visible the cycle after the access edge.
- Inputs must be held stable by upstream while stall=1. The block samples the address/data at the access edge.
- Output register update on each non-reset edge:
  - Stall cycle: insert a bubble. reg_write_out<=0, destination_out<=0, wb_data_out<=0, align_fault_out<=0.
  - Otherwise:
    - destination_out<=destination_in.
    - reg_write_out<=reg_write_in & ~fault.
    - wb_data_out<=(mem_read_in & ~mem_write_in & mem_to_reg_in) ? load_value : alu_result_in.
    - align_fault_out<=fault.
- Non-memory ops: stall=0; outputs are registered with 1-cycle latency.
- Store followed immediately by a load of the same address returns the new data. There is no forwarding hazard because accesses are serialized by busy.
- Reset while busy: aborts the op. No RAM write occurs, busy/cnt clear, and stall drops combinationally to 0 in the cycle after reset.

Test Plan:
- WAIT_STATES=2: sw PB=0xDEADBEEF, addr 0x10 → stall high for 2 cycles, low on the 3rd; RAM 0x10..0x13 = DE AD BE EF; reg_write_out=0 for a store with reg_write_in=0.
- Loads from 0x10 after the store above:
  - lw 0x10 → wb_data_out=0xDEADBEEF, 3 cycles after presentation.
  - lb (signed) 0x10 → 0xFFFFFFDE.
  - lbu 0x13 → 0x000000EF.
  - lh (signed) 0x12 → 0xFFFFBEEF.
  - lhu 0x10 → 0x0000DEAD.
- ALU op alu_result_in=0x00000042, dest=5, reg_write=1 → stall=0; next cycle wb_data_out=0x42, destination_out=5, reg_write_out=1.
- lw at 0x11, reg_write_in=1 → after wait states: align_fault_out=1 for one cycle, wb_data_out=0, reg_write_out=0; sh at 0x03 leaves RAM unchanged.
- sb PB=0x000000AA at addr 0x00000400 (DEPTH=1024) → lbu 0x0 returns 0xAA (aliasing).
- sw issued, reset asserted during the 2nd stall cycle → no RAM write (old value still read back), all outputs 0, stall=0 after reset; WAIT_STATES=0 build: sw/lw complete with stall never asserted.
